// File: rtl/cfg_bus_master_pkg.sv
// cfg_bus_master_pkg: shared config bus widths, responder addresses and master FSM encoding.
package cfg_bus_master_pkg;
    localparam int WIDTH_CONFIG_ADDR = 4;
    localparam int WIDTH_CONFIG_DATA = 8;
    localparam int CFG_TIMEOUT = 16;
    localparam logic [WIDTH_CONFIG_ADDR-1:0] CFG_ADDR_UART_CTRL = 4'h5;
    localparam logic [WIDTH_CONFIG_ADDR-1:0] CFG_ADDR_UART_BAUD = 4'h6;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2
    } cfg_state_t;
endpackage

// File: rtl/cfg_bus_master_fifo.sv
// cfg_req_fifo: synchronous request FIFO with extra-MSB pointers for full/empty.
module cfg_req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = wp == {~rp[AW], rp[AW-1:0]};
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/cfg_bus_master.sv
// cfg_bus_master: queues write requests and issues each as one acknowledged or timed-out config bus transfer.
module cfg_bus_master #(
    parameter int WIDTH_CONFIG_ADDR = cfg_bus_master_pkg::WIDTH_CONFIG_ADDR,
    parameter int WIDTH_CONFIG_DATA = cfg_bus_master_pkg::WIDTH_CONFIG_DATA,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = cfg_bus_master_pkg::CFG_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    input  logic [WIDTH_CONFIG_ADDR-1:0] req_addr,
    input  logic [WIDTH_CONFIG_DATA-1:0] req_data,
    output logic                         req_ready,
    output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    output logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_valid,
    input  logic                         c_ready,
    output logic                         rsp_valid,
    output logic                         rsp_err,
    output logic [WIDTH_CONFIG_ADDR-1:0] rsp_addr,
    output logic                         busy
);
    import cfg_bus_master_pkg::*;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    cfg_state_t state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic c_valid_d, rsp_valid_d, rsp_err_d, full, empty, pop;
    logic [WIDTH_CONFIG_ADDR-1:0] c_addr_d, rsp_addr_d, head_addr;
    logic [WIDTH_CONFIG_DATA-1:0] c_data_d, head_data;

    assign req_ready = !full;
    assign busy = !empty || state != IDLE;

    cfg_req_fifo #(
        .WIDTH(WIDTH_CONFIG_ADDR + WIDTH_CONFIG_DATA),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(req_valid && !full),
        .pop(pop),
        .din({req_addr, req_data}),
        .dout({head_addr, head_data}),
        .full(full),
        .empty(empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            c_valid <= 1'b0;
            c_addr <= '0;
            c_data <= '0;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            rsp_addr <= '0;
        end else begin
            state <= state_d;
            timer <= timer_d;
            c_valid <= c_valid_d;
            c_addr <= c_addr_d;
            c_data <= c_data_d;
            rsp_valid <= rsp_valid_d;
            rsp_err <= rsp_err_d;
            rsp_addr <= rsp_addr_d;
        end
    end

    // c_ready low while idle means a responder still holds the bus, so launch waits for it
    always_comb begin
        state_d = state;
        timer_d = timer;
        c_valid_d = c_valid;
        c_addr_d = c_addr;
        c_data_d = c_data;
        rsp_valid_d = 1'b0;
        rsp_err_d = rsp_err;
        rsp_addr_d = rsp_addr;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty && c_ready) begin
                pop = 1'b1;
                c_addr_d = head_addr;
                c_data_d = head_data;
                c_valid_d = 1'b1;
                timer_d = '0;
                state_d = DRIVE;
            end
            DRIVE: if (!c_ready || timer == TLAST) begin
                c_valid_d = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d = c_ready;
                rsp_addr_d = c_addr;
                state_d = RELEASE;
            end else timer_d = timer + TW'(1);
            RELEASE: begin
                c_valid_d = 1'b0;
                state_d = c_ready ? IDLE : RELEASE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cfg_bus_master.sv
// tb_cfg_bus_master: directed stimulus with a transaction-level bus model and a per-cycle compare process.
module tb_cfg_bus_master;
    logic clk = 0, rst_n = 0, req_valid = 0;
    logic [3:0] req_addr = 0;
    logic [7:0] req_data = 0;
    logic req_ready, c_valid, rsp_valid, rsp_err, busy;
    logic [3:0] c_addr, rsp_addr;
    logic [7:0] c_data;
    wire c_ready;
    int tests = 0, fails = 0;
    bit ack = 0, stuck = 0, mute = 0;
    int hold_len = 0, hold_cnt = 0;

    assign c_ready = !(ack || hold_cnt != 0 || stuck);
    always #5 clk = ~clk;

    cfg_bus_master dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .c_addr(c_addr), .c_data(c_data),
        .c_valid(c_valid), .c_ready(c_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_addr(rsp_addr), .busy(busy)
    );

    function automatic bit mapped(logic [3:0] a);
        return a == 4'h5 || a == 4'h6;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // responder at addresses 5/6: acks from the cycle after it sees c_valid, optionally stretched
    initial begin
        bit s;
        forever begin
            @(negedge clk);
            s = rst_n && c_valid && mapped(c_addr) && !mute;
            @(posedge clk);
            #1;
            if (ack && !s) hold_cnt = hold_len;
            else if (hold_cnt > 0) hold_cnt--;
            ack = s;
        end
    end

    typedef struct {logic [3:0] a; logic [7:0] d;} ent_t;
    ent_t fifo_q[$];
    ent_t pend_e, e;
    bit pend_push, prev_cv, active, releasing, exp_launch, cur_err, rise, fall;
    logic [3:0] cur_addr, last_rsp_addr, last_to_addr;
    logic [7:0] cur_data;
    int hi_len, rsp_cnt = 0, last_to_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            fifo_q.delete();
            {pend_push, prev_cv, active, releasing, exp_launch} = '0;
            last_rsp_addr = '0;
            chk("rst_c_valid", c_valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_c_addr", c_addr, 0);
            chk("rst_rsp_addr", rsp_addr, 0);
        end else begin
            if (pend_push) fifo_q.push_back(pend_e);
            rise = c_valid && !prev_cv;
            fall = !c_valid && prev_cv;
            chk("launch", rise, exp_launch);
            if (rise && fifo_q.size() > 0) begin
                e = fifo_q.pop_front();
                chk("launch_addr", c_addr, e.a);
                chk("launch_data", c_data, e.d);
                cur_addr = e.a;
                cur_data = e.d;
                cur_err = !mapped(e.a) || mute;
                hi_len = 0;
                active = 1;
            end
            if (c_valid) begin
                hi_len++;
                chk("hold_addr", c_addr, cur_addr);
                chk("hold_data", c_data, cur_data);
            end
            chk("rsp_valid", rsp_valid, fall);
            if (fall) begin
                chk("rsp_addr", rsp_addr, cur_addr);
                chk("rsp_err", rsp_err, cur_err);
                chk("cv_len", hi_len, cur_err ? 16 : 2);
                last_rsp_addr = cur_addr;
                rsp_cnt++;
                releasing = 1;
                if (cur_err) begin
                    last_to_len = hi_len;
                    last_to_addr = cur_addr;
                end
            end else chk("rsp_addr_hold", rsp_addr, last_rsp_addr);
            chk("req_ready", req_ready, fifo_q.size() < 4);
            chk("busy", busy, fifo_q.size() > 0 || active);
            exp_launch = !active && fifo_q.size() > 0 && c_ready;
            if (releasing && c_ready) begin
                releasing = 0;
                active = 0;
            end
            pend_push = req_valid && req_ready;
            pend_e = '{req_addr, req_data};
            prev_cv = c_valid;
        end
    end

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        bit ok = 0;
        req_valid = 1;
        req_addr = a;
        req_data = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("push_bound", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = !busy && c_ready && !c_valid;
        end
        if (!done) chk("idle_bound", 0, 1);
        @(posedge clk);
        #1;
    endtask

    int n0;
    initial begin
        repeat (3) @(negedge clk);
        chk("t0_req_ready", req_ready, 1);
        chk("t0_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1;

        push(4'h5, 8'h02);
        req_valid = 0;
        @(negedge clk) chk("t1_cv_early", c_valid, 0);
        @(negedge clk);
        chk("t1_cv_rise", c_valid, 1);
        chk("t1_c_addr", c_addr, 4'h5);
        chk("t1_c_data", c_data, 8'h02);
        @(negedge clk);
        chk("t1_cv_2nd", c_valid, 1);
        chk("t1_no_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("t1_cv_drop", c_valid, 0);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_addr", rsp_addr, 4'h5);
        chk("t1_c_ready_low", c_ready, 0);
        wait_idle();

        n0 = rsp_cnt;
        push(4'h5, 8'h02); push(4'h6, 8'h01); push(4'h5, 8'h03); push(4'h6, 8'h00);
        req_valid = 0;
        wait_idle();
        chk("t2_rsp_count", rsp_cnt - n0, 4);
        chk("t2_last_addr", rsp_addr, 4'h6);

        n0 = rsp_cnt;
        push(4'hF, 8'hAA); push(4'h6, 8'h11);
        req_valid = 0;
        wait_idle();
        chk("t3_timeout_len", last_to_len, 16);
        chk("t3_timeout_addr", last_to_addr, 4'hF);
        chk("t3_rsp_count", rsp_cnt - n0, 2);
        chk("t3_last_addr", rsp_addr, 4'h6);

        mute = 1;
        n0 = rsp_cnt;
        push(4'h5, 8'h01); push(4'h6, 8'h02); push(4'h5, 8'h03); push(4'h6, 8'h04); push(4'h5, 8'h05);
        req_addr = 4'h6;
        req_data = 8'h06;
        @(negedge clk) chk("t4_full", req_ready, 0);
        push(4'h6, 8'h06);
        req_valid = 0;
        wait_idle();
        mute = 0;
        chk("t4_rsp_count", rsp_cnt - n0, 6);

        hold_len = 5;
        n0 = rsp_cnt;
        push(4'h6, 8'h09); push(4'h5, 8'h0A);
        req_valid = 0;
        wait_idle();
        hold_len = 0;
        chk("t5_rsp_count", rsp_cnt - n0, 2);

        stuck = 1;
        n0 = rsp_cnt;
        push(4'h5, 8'h07);
        req_valid = 0;
        repeat (10) @(negedge clk);
        chk("t6_no_launch", c_valid, 0);
        chk("t6_busy", busy, 1);
        chk("t6_no_rsp", rsp_cnt - n0, 0);
        @(posedge clk);
        #1 stuck = 0;
        wait_idle();
        chk("t6_rsp_count", rsp_cnt - n0, 1);

        n0 = rsp_cnt;
        push(4'h6, 8'h0C); push(4'h5, 8'h0D); push(4'h6, 8'h0E);
        req_valid = 0;
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = c_valid;
            end
            if (!seen) chk("t7_drive_bound", 0, 1);
        end
        #2 rst_n = 0;
        #1;
        chk("t7_async_cv", c_valid, 0);
        chk("t7_async_busy", busy, 0);
        chk("t7_async_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t7_post_cv", c_valid, 0);
            chk("t7_post_rsp", rsp_valid, 0);
            chk("t7_post_busy", busy, 0);
        end
        chk("t7_rsp_count", rsp_cnt - n0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
